// File: rtl/reg_file_wb_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_wb_if : write-back and read-port bundle for reg_file_wb   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface reg_file_wb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  w_en;
   logic                  w_waddr_sel;
   logic [ADDR_WIDTH-1:0] w_rt_addr;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_stall;
   logic [ADDR_WIDTH-1:0] w_raddr_a;
   logic [ADDR_WIDTH-1:0] w_raddr_b;
   logic [DATA_WIDTH-1:0] w_rdata_a;
   logic [DATA_WIDTH-1:0] w_rdata_b;
   logic                  w_pend_valid;

   modport master (
      output w_en, w_waddr_sel, w_rt_addr, w_rd_addr, w_wdata, w_stall,
             w_raddr_a, w_raddr_b,
      input  w_rdata_a, w_rdata_b, w_pend_valid
   );

   modport slave (
      input  w_en, w_waddr_sel, w_rt_addr, w_rd_addr, w_wdata, w_stall,
             w_raddr_a, w_raddr_b,
      output w_rdata_a, w_rdata_b, w_pend_valid
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_wb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | reg_file_wb : MIPS write-back register file, one pending-write     |
// | stage, two fully forwarded combinational read ports. Rev 1.0       |
// +--------------------------------------------------------------------+
module reg_file_wb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  wire logic     clock,
   input  wire logic     reset,
   reg_file_wb_if.slave  bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic                  r_pend_valid;
   logic [ADDR_WIDTH-1:0] r_pend_addr;
   logic [DATA_WIDTH-1:0] r_pend_data;

   logic [ADDR_WIDTH-1:0] w_waddr;
   logic                  w_iw;
   logic [ADDR_WIDTH-1:0] w_raddr [2];
   logic [DATA_WIDTH-1:0] w_rdata [2];

   // Select is only looked at under w_en so an undriven select cannot leak.
   always_comb begin
      w_waddr = '0;
      if (bus.w_en) begin
         w_waddr = bus.w_waddr_sel ? bus.w_rt_addr : bus.w_rd_addr;
      end
   end

   assign w_iw = reset & bus.w_en & ~bus.w_stall & (w_waddr != '0);

   assign w_raddr[0] = bus.w_raddr_a;
   assign w_raddr[1] = bus.w_raddr_b;

   // Youngest value wins: incoming write, then pending write, then array.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rdata[p] = r_regs[w_raddr[p]];
         if (w_raddr[p] == '0) begin
            w_rdata[p] = '0;
         end else if (w_iw && (w_waddr == w_raddr[p])) begin
            w_rdata[p] = bus.w_wdata;
         end else if (r_pend_valid && (r_pend_addr == w_raddr[p])) begin
            w_rdata[p] = r_pend_data;
         end
      end
   end

   assign bus.w_rdata_a    = w_rdata[0];
   assign bus.w_rdata_b    = w_rdata[1];
   assign bus.w_pend_valid = r_pend_valid;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_pend_data  <= '0;
      end else begin
         r_pend_valid <= w_iw;
         if (w_iw) begin
            r_pend_addr <= w_waddr;
            r_pend_data <= bus.w_wdata;
         end
         if (r_pend_valid) begin
            r_regs[r_pend_addr] <= r_pend_data;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_reg_file_wb : directed + randomized checks against an           |
// | architectural register model. Rev 1.0                              |
// +--------------------------------------------------------------------+
module tb_reg_file_wb;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] m_regs [32];
   logic        m_pend;
   logic [31:0] last_a, last_b;

   reg_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

   reg_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Architectural view: a write is visible as soon as it is presented.
   function automatic logic [31:0] m_read(input logic [4:0] r, input logic iw,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
      if (iw && wa == r) return wd;
      return m_regs[r];
   endfunction

   task automatic cyc(input logic en, input logic sel, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] wd, input logic st,
                      input logic rn, input logic [4:0] ra, input logic [4:0] rb);
      logic [4:0] wa;
      logic       iw;
      bus.w_en = en; bus.w_waddr_sel = sel; bus.w_rt_addr = rt; bus.w_rd_addr = rd;
      bus.w_wdata = wd; bus.w_stall = st; bus.w_raddr_a = ra; bus.w_raddr_b = rb;
      reset = rn;
      wa = 5'd0;
      if (en) wa = sel ? rt : rd;
      iw = rn && en && !st && (wa != 5'd0);
      #2;
      last_a = bus.w_rdata_a;
      last_b = bus.w_rdata_b;
      if (rn) begin
         chk("rdata_a", last_a, m_read(ra, iw, wa, wd));
         chk("rdata_b", last_b, m_read(rb, iw, wa, wd));
      end
      @(posedge clock);
      if (!rn) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_pend = 1'b0;
      end else begin
         if (iw) m_regs[wa] = wd;
         m_pend = iw;
      end
      #1;
      chk("pend_valid", {31'd0, bus.w_pend_valid}, {31'd0, m_pend});
      @(negedge clock);
   endtask

   task automatic idle_rd(input logic [4:0] ra, input logic [4:0] rb);
      cyc(1'b0, 1'bx, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1, ra, rb);
   endtask

   task automatic dump_all();
      for (int i = 0; i < 32; i++) idle_rd(5'(i), 5'(31 - i));
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pend = 1'b0;
      @(negedge clock);
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);

      // Random writes, then a two-cycle reset clears everything.
      for (int i = 0; i < 10; i++)
         cyc(1'b1, 1'($urandom), 5'($urandom), 5'($urandom), $urandom, 1'b0, 1'b1,
             5'($urandom), 5'($urandom));
      cyc(1'b1, 1'b0, 5'd0, 5'd6, 32'h1111, 1'b0, 1'b1, 5'd6, 5'd6);
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
      dump_all();
      idle_rd(5'd6, 5'd6);
      chk("reset_r6", last_a, 32'd0);

      // ALU write to rd=5; rt=9 untouched.
      cyc(1'b1, 1'b0, 5'd9, 5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 5'd5, 5'd9);
      chk("alu_N", last_a, 32'hDEADBEEF);
      chk("alu_r9", last_b, 32'd0);
      idle_rd(5'd5, 5'd5);
      chk("alu_N1", last_a, 32'hDEADBEEF);
      idle_rd(5'd5, 5'd9);
      chk("alu_N2", last_a, 32'hDEADBEEF);
      chk("alu_r9_N2", last_b, 32'd0);

      // Load write to rt=9, then idle with X select.
      cyc(1'b1, 1'b1, 5'd9, 5'd5, 32'h12345678, 1'b0, 1'b1, 5'd9, 5'd9);
      chk("load_N", last_b, 32'h12345678);
      cyc(1'b0, 1'bx, 5'd9, 5'd5, 32'hBAD0BAD0, 1'b0, 1'b1, 5'd9, 5'd5);
      chk("load_xsel", last_a, 32'h12345678);
      idle_rd(5'd9, 5'd5);
      chk("load_arr", last_a, 32'h12345678);

      // Back-to-back writes to r7.
      cyc(1'b1, 1'b0, 5'd0, 5'd7, 32'h1, 1'b0, 1'b1, 5'd7, 5'd7);
      chk("b2b_0", last_a, 32'h1);
      cyc(1'b1, 1'b0, 5'd0, 5'd7, 32'h2, 1'b0, 1'b1, 5'd7, 5'd7);
      chk("b2b_1", last_a, 32'h2);
      idle_rd(5'd7, 5'd7);
      chk("b2b_2", last_b, 32'h2);
      idle_rd(5'd7, 5'd7);
      chk("b2b_3", last_a, 32'h2);

      // r0 write ignored; stalled write to r3 ignored.
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 5'd0, 5'd0);
      chk("r0_wr", last_a, 32'd0);
      cyc(1'b1, 1'b0, 5'd0, 5'd3, 32'hAA, 1'b1, 1'b1, 5'd3, 5'd0);
      chk("stall_N", last_a, 32'd0);
      idle_rd(5'd3, 5'd0);
      chk("stall_N1", last_a, 32'd0);

      // Reset right behind a write drops the pending entry.
      cyc(1'b1, 1'b0, 5'd0, 5'd4, 32'h55, 1'b0, 1'b1, 5'd4, 5'd4);
      chk("rst_mid_N", last_a, 32'h55);
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd4, 5'd4);
      idle_rd(5'd4, 5'd9);
      chk("rst_mid_r4", last_a, 32'd0);
      chk("rst_mid_r9", last_b, 32'd0);

      // Randomized traffic biased toward a few registers to provoke collisions.
      for (int i = 0; i < 600; i++) begin
         logic [4:0] ra, rb, rt, rd;
         ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rt = 5'($urandom_range(0, 7));
         rd = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), rt, rd, $urandom,
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 49) != 0), ra, rb);
      end
      dump_all();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/reg_file_wb.md
# reg_file_wb

Write-back register file for the pd3 MIPS datapath, sitting directly downstream of the register-file write-address controller. It consumes the controller's write enable and destination-select bit, picks the destination register (rd for ALU results, rt for loads), and commits the write-back data through a one-entry pending-write stage. Two combinational read ports with full forwarding make every write visible to readers in the same cycle it is presented.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH

Ports:
- clock  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- w_en  input  1  write enable from the write-address controller
- w_waddr_sel  input  1  destination select: 1 = rt (load), 0 = rd (ALU); don't-care (may be X) when w_en=0
- w_rt_addr  input  ADDR_WIDTH  rt field of the instruction
- w_rd_addr  input  ADDR_WIDTH  rd field of the instruction
- w_wdata  input  DATA_WIDTH  write-back data
- w_stall  input  1  pipeline stall; blocks capture of a new write
- w_raddr_a, w_raddr_b  input  ADDR_WIDTH  read addresses
- w_rdata_a, w_rdata_b  output  DATA_WIDTH  read data (combinational)
- w_pend_valid  output  1  pending-write stage occupied (debug/verification)

## Operation
- Destination: waddr = w_waddr_sel ? w_rt_addr : w_rd_addr. w_waddr_sel is never evaluated when w_en=0; X on it then must not propagate.
- Incoming write active (iw) = w_en & ~w_stall & (waddr != 0).
- Capture (each edge): pend_valid <= iw; if iw, pend_addr <= waddr, pend_data <= w_wdata. Otherwise pend_addr/pend_data hold.
- Commit (same edge): if pend_valid, regs[pend_addr] <= pend_data. Capture and commit proceed together; no back-pressure.
- Register 0: never written, always reads 0.
- Read priority per port (addr r): r == 0 -> 0; else iw & waddr == r -> w_wdata; else pend_valid & pend_addr == r -> pend_data; else regs[r].
- Stall: suppresses capture only; an already pending write still commits and pend_valid clears.
- Reset (reset=0 at edge): all regs <= 0, pend_valid <= 0, pend_addr/pend_data <= 0; a pending write at that edge is dropped; incoming write ignored. Read forwarding from w_wdata remains combinational during reset cycles only if iw; iw is forced 0 while reset=0.

## Timing
- Reset values: w_pend_valid = 0; w_rdata_a/b = 0 for all addresses once reset has been sampled.
- Write presented in cycle N: visible on read ports in cycle N (bypass), held in pending stage during N+1, in array from N+2.
- Back-to-back writes to the same address in N and N+1: cycle N+1 reads return the N+1 data (incoming beats pending); array ends with N+1 data.
- Write to r0 or with w_en=0: no capture, pend_valid = 0 next cycle, reads unchanged.
- Both read ports may address the same register, including the one being written; both return identical forwarded data.
- Read path is purely combinational; no read latency. Write latency to array: 2 edges.

## Test plan
- Reset: hold reset=0 two cycles after random writes -> all 32 registers read 0, w_pend_valid=0.
- ALU write: w_en=1, sel=0, rd=5, rt=9, wdata=0xDEADBEEF -> raddr_a=5 reads 0xDEADBEEF same cycle, N+1, N+2; reg 9 stays 0.
- Load write with X select elsewhere: sel=1, rt=9, wdata=0x12345678 -> reg 9 = 0x12345678; following cycle w_en=0, sel=X -> no X on any read, w_pend_valid=0.
- Back-to-back same address: writes 0x1 then 0x2 to reg 7 in consecutive cycles -> reg 7 reads 0x1, 0x2, 0x2, 0x2.
- r0 and stall: write 0xFFFFFFFF to rd=0 -> reg 0 reads 0; write 0xAA to rd=3 with w_stall=1 -> reg 3 unchanged, w_pend_valid=0.
- Reset mid-operation: write 0x55 to reg 4, assert reset=0 on the next edge -> reg 4 reads 0, w_pend_valid=0.
